// File: rtl/seq_detect_scheduler_if.sv
// Channel handshake, detection and readback bus for seq_detect_scheduler.
interface seq_detect_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 4,
   parameter int CH_W   = 2,
   parameter int EVT_W  = 16
);
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH-1:0] ch_bit;
   logic [NUM_CH-1:0] ch_ready;
   logic [NUM_CH-1:0] ch_enable;
   logic [NUM_CH-1:0] ch_clr;
   logic              det_valid;
   logic [CH_W-1:0]   det_ch;
   logic [EVT_W-1:0]  evt_count;
   logic [CH_W-1:0]   rd_sel;
   logic [CNT_W-1:0]  rd_cnt;

   modport master (
      output ch_valid, ch_bit, ch_enable, ch_clr, rd_sel,
      input  ch_ready, det_valid, det_ch, evt_count, rd_cnt
   );

   modport slave (
      input  ch_valid, ch_bit, ch_enable, ch_clr, rd_sel,
      output ch_ready, det_valid, det_ch, evt_count, rd_cnt
   );
endinterface

// File: rtl/seq_detect_scheduler.sv
// Round-robin sharing of one mod-MOD "ones" detector across NUM_CH serial
// channels; each channel's running count lives in a small context file.
module seq_detect_scheduler #(
   parameter int NUM_CH = 4,
   parameter int MOD    = 3,
   parameter int CNT_W  = 4,
   parameter int CH_W   = 2,
   parameter int EVT_W  = 16
) (
   input logic                  clk,
   input logic                  reset,
   seq_detect_scheduler_if.slave bus
);

   logic [CNT_W-1:0]  ctx [NUM_CH];
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   gnt_idx;
   logic [CH_W-1:0]   idx;
   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] grant;
   logic              found;
   logic              xfer;
   logic              gbit;
   logic [CNT_W-1:0]  nxt;

   assign elig = bus.ch_valid & bus.ch_enable & ~bus.ch_clr;

   // Search starts one past the last winner, so the last winner has lowest priority.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = CH_W'((32'(rr_ptr) + k) % NUM_CH);
         if (!found && elig[idx]) begin
            found        = 1'b1;
            grant[idx]   = 1'b1;
            gnt_idx      = idx;
         end
      end
      if (reset) begin
         grant = '0;
         found = 1'b0;
      end
   end

   assign bus.ch_ready = grant;
   assign xfer         = |(bus.ch_valid & grant);
   assign gbit         = bus.ch_bit[gnt_idx];
   assign nxt          = ctx[gnt_idx] + CNT_W'(1);
   assign bus.rd_cnt   = (int'(bus.rd_sel) < NUM_CH) ? ctx[bus.rd_sel] : '0;

   // A cleared channel is never granted in the same cycle, so the two writes never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) ctx[i] <= '0;
         rr_ptr        <= CH_W'(NUM_CH - 1);
         bus.det_valid <= 1'b0;
         bus.det_ch    <= '0;
         bus.evt_count <= '0;
      end else begin
         bus.det_valid <= 1'b0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.ch_clr[i]) ctx[i] <= '0;
         end
         if (xfer) begin
            rr_ptr <= gnt_idx;
            if (gbit) begin
               if (nxt == CNT_W'(MOD)) begin
                  ctx[gnt_idx]  <= '0;
                  bus.det_valid <= 1'b1;
                  bus.det_ch    <= gnt_idx;
                  if (bus.evt_count != '1) bus.evt_count <= bus.evt_count + EVT_W'(1);
               end else begin
                  ctx[gnt_idx] <= nxt;
               end
            end
         end
      end
   end

endmodule
